// File: rtl/sniffer_pkg.sv
// Shared types, default sizes and the case-folding helper for the
// multi-pattern stream comparator.
package sniffer_pkg;

  localparam int MAX_LEN    = 17;
  localparam int DATA_BYTES = 4;

  typedef logic [7:0] byte_t;

  // One programmed pattern slot at the default sizing.
  typedef struct packed {
    logic [MAX_LEN*8-1:0]         str;
    logic [$clog2(MAX_LEN+1)-1:0] len;
    logic                         nocase;
  } pattern_t;

  // Fold ASCII upper case to lower case; every other byte passes unchanged.
  function automatic byte_t to_lower(input byte_t b);
    return (b >= 8'h41 && b <= 8'h5A) ? b + 8'h20 : b;
  endfunction

endpackage

// File: rtl/pattern_matcher.sv
// Single pattern slot: compares the history+current-word window against one
// programmed pattern at every byte offset of the current word.
module pattern_matcher #(
  parameter int MAX_LEN    = sniffer_pkg::MAX_LEN,
  parameter int DATA_BYTES = sniffer_pkg::DATA_BYTES,
  parameter int LEN_W      = $clog2(MAX_LEN+1)
) (
  input  logic [(MAX_LEN-1)*8-1:0] history,
  input  logic [DATA_BYTES*8-1:0]  word,
  input  logic [MAX_LEN*8-1:0]     pat_str,
  input  logic [LEN_W-1:0]         pat_len,
  input  logic                     pat_nocase,
  output logic                     hit
);
  import sniffer_pkg::*;

  // Window byte 0 is the oldest history byte; byte MAX_LEN-1+k is word byte k.
  localparam int WIN = MAX_LEN - 1 + DATA_BYTES;

  logic [WIN*8-1:0] window;
  byte_t            win_b [WIN];
  byte_t            pat_b [MAX_LEN];

  assign window = {history, word};

  // Split window and pattern into bytes, folding both sides when enabled.
  always_comb begin
    for (int i = 0; i < WIN; i++) begin
      win_b[i] = pat_nocase ? to_lower(window[(WIN-i)*8-1 -: 8]) : window[(WIN-i)*8-1 -: 8];
    end
    for (int j = 0; j < MAX_LEN; j++) begin
      pat_b[j] = pat_nocase ? to_lower(pat_str[(MAX_LEN-j)*8-1 -: 8]) : pat_str[(MAX_LEN-j)*8-1 -: 8];
    end
  end

  // Hit if the pattern ends exactly at any byte of the current word.
  // NOTE: every variable gets a value before any branch so no latch is inferred.
  always_comb begin
    int   len_i;
    int   start;
    logic eq;
    hit   = 1'b0;
    len_i = int'(pat_len);
    start = 0;
    eq    = 1'b0;
    if (len_i >= 1 && len_i <= MAX_LEN) begin
      for (int k = 0; k < DATA_BYTES; k++) begin
        // First window byte of a len_i-byte string ending at word byte k.
        start = MAX_LEN - len_i + k;
        eq    = 1'b1;
        for (int j = 0; j < MAX_LEN; j++) begin
          if (j < len_i) begin
            if (win_b[start+j] != pat_b[j]) eq = 1'b0;
          end
        end
        hit = hit | eq;
      end
    end
  end

endmodule

// File: rtl/multi_string_comparator.sv
// Multi-pattern stream comparator: shared history buffer, NUM_PATTERNS
// matcher slots, sticky hit register and a fixed data delay line long enough
// that a match is flagged before the matched string leaves data_out.
module multi_string_comparator #(
  parameter  int NUM_PATTERNS = 4,
  parameter  int MAX_LEN      = sniffer_pkg::MAX_LEN,
  parameter  int DATA_BYTES   = sniffer_pkg::DATA_BYTES,
  localparam int LEN_W        = $clog2(MAX_LEN+1),
  localparam int SEL_W        = $clog2(NUM_PATTERNS),
  localparam int DELAY        = (MAX_LEN + 2*DATA_BYTES - 2) / DATA_BYTES + 1
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    data_valid,
  input  logic [8*DATA_BYTES-1:0] data_in,
  input  logic                    cfg_wr,
  input  logic [SEL_W-1:0]        cfg_sel,
  input  logic [MAX_LEN*8-1:0]    cfg_string,
  input  logic [LEN_W-1:0]        cfg_len,
  input  logic                    cfg_nocase,
  output logic                    match,
  output logic [NUM_PATTERNS-1:0] match_vec,
  output logic [SEL_W-1:0]        match_idx,
  output logic [8*DATA_BYTES-1:0] data_out,
  output logic                    data_out_valid
);

  logic [MAX_LEN*8-1:0]            pat_str    [NUM_PATTERNS];
  logic [LEN_W-1:0]                pat_len    [NUM_PATTERNS];
  logic                            pat_nocase [NUM_PATTERNS];

  logic [(MAX_LEN-1)*8-1:0]        history;
  logic [(MAX_LEN-1+DATA_BYTES)*8-1:0] window_full;
  logic [NUM_PATTERNS-1:0]         hit;
  logic                            accept;

  logic [NUM_PATTERNS-1:0]         match_vec_next;
  logic [SEL_W-1:0]                match_idx_next;

  logic [8*DATA_BYTES-1:0]         data_pipe [DELAY];
  logic [DELAY-1:0]                valid_pipe;

  assign accept      = data_valid & ~clear;
  assign window_full = {history, data_in};

  // Pattern slot configuration.
  // NOTE: the slot table is a register file, yet it is reset because reset
  // must leave every slot disabled.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int s = 0; s < NUM_PATTERNS; s++) begin
        pat_str[s]    <= '0;
        pat_len[s]    <= '0;
        pat_nocase[s] <= 1'b0;
      end
    end else if (cfg_wr && int'(cfg_sel) < NUM_PATTERNS) begin
      // NOTE: sequential state uses non-blocking assignments so all registers
      // update from pre-edge values regardless of statement order.
      pat_str[cfg_sel]    <= cfg_string;
      pat_len[cfg_sel]    <= cfg_len;
      pat_nocase[cfg_sel] <= cfg_nocase;
    end
  end

  // One matcher per slot, all looking at the same window.
  for (genvar s = 0; s < NUM_PATTERNS; s++) begin : g_slot
    pattern_matcher #(
      .MAX_LEN   (MAX_LEN),
      .DATA_BYTES(DATA_BYTES),
      .LEN_W     (LEN_W)
    ) u_matcher (
      .history   (history),
      .word      (data_in),
      .pat_str   (pat_str[s]),
      .pat_len   (pat_len[s]),
      .pat_nocase(pat_nocase[s]),
      .hit       (hit[s])
    );
  end

  // History keeps the newest MAX_LEN-1 bytes of accepted words.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      history <= '0;
    end else if (clear) begin
      history <= '0;
    end else if (data_valid) begin
      history <= window_full[(MAX_LEN-1)*8-1:0];
    end
  end

  // Next sticky vector with precedence clear > config write > hit, plus the
  // lowest-set-index encoder.
  // NOTE: blocking assignments here model combinational logic evaluated in order.
  always_comb begin
    match_vec_next = match_vec;
    for (int s = 0; s < NUM_PATTERNS; s++) begin
      if (accept && hit[s]) match_vec_next[s] = 1'b1;
      if (cfg_wr && int'(cfg_sel) == s) match_vec_next[s] = 1'b0;
    end
    if (clear) match_vec_next = '0;
    match_idx_next = '0;
    for (int s = NUM_PATTERNS - 1; s >= 0; s--) begin
      if (match_vec_next[s]) match_idx_next = SEL_W'(s);
    end
  end

  // Registered match outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      match_vec <= '0;
      match     <= 1'b0;
      match_idx <= '0;
    end else begin
      match_vec <= match_vec_next;
      match     <= |match_vec_next;
      match_idx <= match_idx_next;
    end
  end

  // Fixed delay line for data and valid; clear flushes every stage.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int d = 0; d < DELAY; d++) data_pipe[d] <= '0;
      valid_pipe <= '0;
    end else if (clear) begin
      for (int d = 0; d < DELAY; d++) data_pipe[d] <= '0;
      valid_pipe <= '0;
    end else begin
      data_pipe[0] <= data_in;
      for (int d = 1; d < DELAY; d++) data_pipe[d] <= data_pipe[d-1];
      valid_pipe <= {valid_pipe[DELAY-2:0], data_valid};
    end
  end

  assign data_out       = data_pipe[DELAY-1];
  assign data_out_valid = valid_pipe[DELAY-1];

endmodule

// File: tb/tb_multi_string_comparator.sv
// Directed bench for multi_string_comparator: vector tables for the single
// word cases, hand sequences for straddling, gaps, clear and reset.
module tb_multi_string_comparator;
  import sniffer_pkg::*;

  localparam int DELAY = 6;
  localparam int ML    = 17;

  typedef struct {
    logic        valid;
    logic        clr;
    logic [31:0] word;
    logic [3:0]  exp_vec;
    logic [1:0]  exp_idx;
  } vec_t;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         clear;
  logic         data_valid;
  logic [31:0]  data_in;
  logic         cfg_wr;
  logic [1:0]   cfg_sel;
  logic [135:0] cfg_string;
  logic [4:0]   cfg_len;
  logic         cfg_nocase;
  logic         match;
  logic [3:0]   match_vec;
  logic [1:0]   match_idx;
  logic [31:0]  data_out;
  logic         data_out_valid;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected delay line contents, stage 0 newest.
  logic [31:0] exp_d [DELAY];
  logic        exp_v [DELAY];

  multi_string_comparator dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (clear),
    .data_valid    (data_valid),
    .data_in       (data_in),
    .cfg_wr        (cfg_wr),
    .cfg_sel       (cfg_sel),
    .cfg_string    (cfg_string),
    .cfg_len       (cfg_len),
    .cfg_nocase    (cfg_nocase),
    .match         (match),
    .match_vec     (match_vec),
    .match_idx     (match_idx),
    .data_out      (data_out),
    .data_out_valid(data_out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_flush();
    for (int d = 0; d < DELAY; d++) begin
      exp_d[d] = '0;
      exp_v[d] = 1'b0;
    end
  endtask

  // Drive one cycle, then check the delayed data against the expected line.
  task automatic step(input logic v, input logic [31:0] w, input logic clr);
    data_valid = v;
    data_in    = w;
    clear      = clr;
    @(posedge clk);
    #1;
    if (clr) begin
      model_flush();
    end else begin
      for (int d = DELAY - 1; d > 0; d--) begin
        exp_d[d] = exp_d[d-1];
        exp_v[d] = exp_v[d-1];
      end
      exp_d[0] = w;
      exp_v[0] = v;
    end
    check("data_out_valid", 32'(data_out_valid), 32'(exp_v[DELAY-1]));
    check("data_out", data_out, exp_d[DELAY-1]);
  endtask

  task automatic apply(input vec_t v, input string tag);
    step(v.valid, v.word, v.clr);
    check({tag, " match_vec"}, 32'(match_vec), 32'(v.exp_vec));
    check({tag, " match"}, 32'(match), 32'(|v.exp_vec));
    check({tag, " match_idx"}, 32'(match_idx), 32'(v.exp_idx));
  endtask

  task automatic idle(input int n, input logic [3:0] ev, input logic [1:0] ei, input string tag);
    vec_t v;
    v = '{1'b0, 1'b0, 32'h0, ev, ei};
    for (int i = 0; i < n; i++) apply(v, tag);
  endtask

  // Left-justify a right-aligned literal of len bytes.
  function automatic logic [135:0] left_just(input logic [135:0] s, input logic [4:0] len);
    if (len == 0 || int'(len) > ML) return s;
    return s << (8 * (ML - int'(len)));
  endfunction

  task automatic cfg(input logic [1:0] sel, input logic [135:0] s, input logic [4:0] len,
                     input logic nc);
    cfg_wr     = 1'b1;
    cfg_sel    = sel;
    cfg_string = left_just(s, len);
    cfg_len    = len;
    cfg_nocase = nc;
    step(1'b0, 32'h0, 1'b0);
    cfg_wr     = 1'b0;
  endtask

  vec_t        t2 [8];
  vec_t        t4 [5];
  logic [111:0] goog;
  logic [159:0] line;
  logic [7:0]   b;
  logic [31:0]  li_words [5];
  logic [3:0]   ev;
  logic [1:0]   ei;

  initial begin
    n_rst = 1'b0; clear = 1'b0; data_valid = 1'b0; data_in = '0;
    cfg_wr = 1'b0; cfg_sel = '0; cfg_string = '0; cfg_len = '0; cfg_nocase = 1'b0;
    model_flush();

    #2;
    check("reset match_vec", 32'(match_vec), 32'h0);
    check("reset match", 32'(match), 32'h0);
    check("reset match_idx", 32'(match_idx), 32'h0);
    check("reset data_out", data_out, 32'h0);
    check("reset data_out_valid", 32'(data_out_valid), 32'h0);
    #20 n_rst = 1'b1;

    // 1: google at each of four alignments; hit after the word holding 'm'.
    cfg(2'd0, "www.google.com", 5'd14, 1'b0);
    goog = "www.google.com";
    for (int a = 0; a < 4; a++) begin
      apply('{1'b0, 1'b1, 32'h0, 4'b0000, 2'd0}, "t1 clear");
      for (int i = 0; i < 20; i++) begin
        b = " ";
        if (i >= a && i - a < 14) b = goog[(14-(i-a))*8-1 -: 8];
        line[(20-i)*8-1 -: 8] = b;
      end
      for (int w = 0; w < 5; w++) begin
        ev = (w >= (13 + a) / 4) ? 4'b0001 : 4'b0000;
        apply('{1'b1, 1'b0, line[(5-w)*32-1 -: 32], ev, 2'd0}, $sformatf("t1 a%0d w%0d", a, w));
      end
      idle(DELAY, 4'b0001, 2'd0, "t1 drain");
    end
    apply('{1'b0, 1'b1, 32'h0, 4'b0000, 2'd0}, "t1 final clear");

    // 2: case-sensitive and case-folded slots, single-word vectors.
    cfg(2'd0, "abc", 5'd3, 1'b0);
    cfg(2'd2, "ABC", 5'd3, 1'b1);
    t2[0] = '{1'b0, 1'b1, 32'h0,  4'b0000, 2'd0};
    t2[1] = '{1'b1, 1'b0, " aBc", 4'b0100, 2'd2};
    t2[2] = '{1'b1, 1'b0, "abc ", 4'b0101, 2'd0};
    t2[3] = '{1'b0, 1'b0, 32'h0,  4'b0101, 2'd0};
    t2[4] = '{1'b0, 1'b1, 32'h0,  4'b0000, 2'd0};
    t2[5] = '{1'b1, 1'b0, "xxAB", 4'b0000, 2'd0};
    t2[6] = '{1'b1, 1'b0, "C   ", 4'b0100, 2'd2};
    t2[7] = '{1'b1, 1'b0, "ab  ", 4'b0100, 2'd2};
    for (int i = 0; i < 8; i++) apply(t2[i], $sformatf("t2 row%0d", i));

    // 3: full-length pattern with two idle cycles between words.
    cfg(2'd1, "www.linkedin.com/", 5'd17, 1'b0);
    apply('{1'b0, 1'b1, 32'h0, 4'b0000, 2'd0}, "t3 clear");
    li_words = '{"www.", "link", "edin", ".com", "/   "};
    for (int w = 0; w < 5; w++) begin
      ev = (w == 4) ? 4'b0010 : 4'b0000;
      ei = (w == 4) ? 2'd1 : 2'd0;
      apply('{1'b1, 1'b0, li_words[w], ev, ei}, $sformatf("t3 w%0d", w));
      idle(2, ev, ei, "t3 gap");
    end
    idle(DELAY, 4'b0010, 2'd1, "t3 drain");

    // 4: near miss, all-zero full-length pattern, disable by len 0 and len > MAX.
    cfg(2'd0, "www.google.com", 5'd14, 1'b0);
    t4[0] = '{1'b0, 1'b1, 32'h0,  4'b0000, 2'd0};
    t4[1] = '{1'b1, 1'b0, "www.", 4'b0000, 2'd0};
    t4[2] = '{1'b1, 1'b0, "goog", 4'b0000, 2'd0};
    t4[3] = '{1'b1, 1'b0, "book", 4'b0000, 2'd0};
    t4[4] = '{1'b1, 1'b0, ".com", 4'b0000, 2'd0};
    for (int i = 0; i < 5; i++) apply(t4[i], $sformatf("t4 row%0d", i));
    cfg(2'd3, 136'h0, 5'd17, 1'b0);
    for (int w = 0; w < 5; w++) begin
      ev = (w == 4) ? 4'b1000 : 4'b0000;
      ei = (w == 4) ? 2'd3 : 2'd0;
      apply('{1'b1, 1'b0, 32'h0, ev, ei}, $sformatf("t4 zero w%0d", w));
    end
    cfg(2'd3, 136'h0, 5'd0, 1'b0);
    check("t4 len0 clears bit", 32'(match_vec), 32'h0);
    apply('{1'b1, 1'b0, 32'h0, 4'b0000, 2'd0}, "t4 len0 disabled");
    cfg(2'd3, 136'h0, 5'd18, 1'b0);
    apply('{1'b1, 1'b0, 32'h0, 4'b0000, 2'd0}, "t4 len18 disabled");

    // 5: clear against a same-cycle hit, history flush, cfg_wr against a hit.
    cfg(2'd0, "abc", 5'd3, 1'b0);
    cfg(2'd2, 136'h0, 5'd0, 1'b0);
    apply('{1'b1, 1'b0, "zzzz", 4'b0000, 2'd0}, "t5 pre");
    apply('{1'b1, 1'b0, "  ab", 4'b0000, 2'd0}, "t5 head");
    apply('{1'b1, 1'b1, "c   ", 4'b0000, 2'd0}, "t5 clear vs hit");
    apply('{1'b1, 1'b0, "c   ", 4'b0000, 2'd0}, "t5 history flushed");
    idle(DELAY, 4'b0000, 2'd0, "t5 drain");
    cfg_wr = 1'b1; cfg_sel = 2'd0; cfg_string = left_just("abc", 5'd3);
    cfg_len = 5'd3; cfg_nocase = 1'b0;
    apply('{1'b1, 1'b0, "abc ", 4'b0000, 2'd0}, "t5 cfg vs hit");
    cfg_wr = 1'b0;
    apply('{1'b1, 1'b0, "abc ", 4'b0001, 2'd0}, "t5 after cfg");

    // 6: asynchronous reset in the middle of a straddling string.
    apply('{1'b1, 1'b0, "www.", 4'b0001, 2'd0}, "t6 w0");
    apply('{1'b1, 1'b0, "link", 4'b0001, 2'd0}, "t6 w1");
    #2 n_rst = 1'b0;
    #1;
    model_flush();
    check("t6 rst match_vec", 32'(match_vec), 32'h0);
    check("t6 rst match", 32'(match), 32'h0);
    check("t6 rst match_idx", 32'(match_idx), 32'h0);
    check("t6 rst data_out", data_out, 32'h0);
    check("t6 rst data_out_valid", 32'(data_out_valid), 32'h0);
    #4 n_rst = 1'b1;
    #1;
    check("t6 released match_vec", 32'(match_vec), 32'h0);
    check("t6 released data_out_valid", 32'(data_out_valid), 32'h0);
    cfg(2'd1, "www.linkedin.com/", 5'd17, 1'b0);
    for (int w = 2; w < 5; w++) begin
      apply('{1'b1, 1'b0, li_words[w], 4'b0000, 2'd0}, $sformatf("t6 tail w%0d", w));
    end
    for (int w = 0; w < 5; w++) begin
      ev = (w == 4) ? 4'b0010 : 4'b0000;
      ei = (w == 4) ? 2'd1 : 2'd0;
      apply('{1'b1, 1'b0, li_words[w], ev, ei}, $sformatf("t6 full w%0d", w));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
